// File: rtl/uart_buf.sv
// uart_buf: TX and RX byte FIFOs between the CPU bus and the uart core.
// The TX FIFO drains one byte per uart_wr pulse whenever the uart reports
// tx_ready. The RX FIFO pulls each byte out of the uart's single-entry
// receive buffer with a uart_rd pulse. Both pulses are registered.
module uart_buf #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BITS-1:0]  tx_wdata,
    input  logic                  tx_push,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [DATA_BITS-1:0]  rx_rdata,
    input  logic                  rx_pop,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  err_push_full,
    output logic                  err_pop_empty,
    input  logic                  err_clr,
    output logic [DATA_BITS-1:0]  uart_tx_data,
    output logic                  uart_wr,
    input  logic                  uart_tx_ready,
    input  logic [DATA_BITS-1:0]  uart_rx_data,
    input  logic                  uart_rx_full,
    output logic                  uart_rd
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DATA_BITS-1:0]  tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wptr;
    logic [DEPTH_LOG2-1:0] tx_rptr;
    logic [CW-1:0]         tx_cnt;

    logic [DATA_BITS-1:0]  rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wptr;
    logic [DEPTH_LOG2-1:0] rx_rptr;
    logic [CW-1:0]         rx_cnt;

    logic tx_do_push;
    logic tx_do_drain;
    logic rx_do_fill;
    logic rx_do_pop;

    // All full/empty decisions use occupancy as it stood before this edge,
    // so a pop never frees room for a same-cycle push/fill.
    assign tx_do_push  = tx_push && (tx_cnt != CNT_FULL);
    // The !uart_wr guard keeps us from issuing again while the uart's
    // tx_ready is still reacting to the previous write.
    assign tx_do_drain = (tx_cnt != '0) && uart_tx_ready && !uart_wr;
    // The !uart_rd guard stops a second read of the same uart byte while
    // rx_full is being cleared by the uart.
    assign rx_do_fill  = uart_rx_full && !uart_rd && (rx_cnt != CNT_FULL);
    assign rx_do_pop   = rx_pop && (rx_cnt != '0);

    assign tx_count = tx_cnt;
    assign tx_full  = (tx_cnt == CNT_FULL);
    assign rx_count = rx_cnt;
    assign rx_empty = (rx_cnt == '0);
    assign rx_rdata = rx_empty ? '0 : rx_mem[rx_rptr];

    // TX storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (tx_do_push) begin
            tx_mem[tx_wptr] <= tx_wdata;
        end
    end

    // TX pointers, occupancy and the registered write strobe to the uart.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr      <= '0;
            tx_rptr      <= '0;
            tx_cnt       <= '0;
            uart_wr      <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            if (tx_do_push) begin
                tx_wptr <= tx_wptr + PTR_ONE;
            end
            if (tx_do_drain) begin
                tx_rptr      <= tx_rptr + PTR_ONE;
                uart_tx_data <= tx_mem[tx_rptr];
            end
            uart_wr <= tx_do_drain;
            case ({tx_do_push, tx_do_drain})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // RX storage array; written from the uart receive buffer, no reset.
    always_ff @(posedge clk) begin
        if (rx_do_fill) begin
            rx_mem[rx_wptr] <= uart_rx_data;
        end
    end

    // RX pointers, occupancy and the registered read strobe to the uart.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
            uart_rd <= 1'b0;
        end else begin
            if (rx_do_fill) begin
                rx_wptr <= rx_wptr + PTR_ONE;
            end
            if (rx_do_pop) begin
                rx_rptr <= rx_rptr + PTR_ONE;
            end
            uart_rd <= rx_do_fill;
            case ({rx_do_fill, rx_do_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Sticky error flags; a new error event outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_push_full <= 1'b0;
            err_pop_empty <= 1'b0;
        end else begin
            if (tx_push && !tx_do_push) begin
                err_push_full <= 1'b1;
            end else if (err_clr) begin
                err_push_full <= 1'b0;
            end
            if (rx_pop && !rx_do_pop) begin
                err_pop_empty <= 1'b1;
            end else if (err_clr) begin
                err_pop_empty <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_buf.sv
// tb_uart_buf: self-checking bench for uart_buf with queue-based reference
// FIFOs, a simple uart model on the far side, a vector table for the error
// flags and directed sequences for the multi-cycle corner cases.
module tb_uart_buf;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_wdata;
    logic       tx_push;
    logic       tx_full;
    logic [4:0] tx_count;
    logic [7:0] rx_rdata;
    logic       rx_pop;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       err_push_full;
    logic       err_pop_empty;
    logic       err_clr;
    logic [7:0] uart_tx_data;
    logic       uart_wr;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_full;
    logic       uart_rd;

    uart_buf #(.DATA_BITS(8), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .tx_wdata(tx_wdata), .tx_push(tx_push), .tx_full(tx_full), .tx_count(tx_count),
        .rx_rdata(rx_rdata), .rx_pop(rx_pop), .rx_empty(rx_empty), .rx_count(rx_count),
        .err_push_full(err_push_full), .err_pop_empty(err_pop_empty), .err_clr(err_clr),
        .uart_tx_data(uart_tx_data), .uart_wr(uart_wr), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_full(uart_rx_full), .uart_rd(uart_rd)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] tx_q[$];    // bytes accepted by the TX FIFO, not yet issued
    logic [7:0] rx_q[$];    // bytes held in the RX FIFO
    logic [7:0] rx_src[$];  // bytes the uart model still has to deliver
    logic [7:0] tx_log[$];  // every byte seen with uart_wr high
    bit ref_wr, ref_rd, e_push, e_pop;
    bit tx_hold, rx_on;
    int tx_gap, busy;

    typedef struct {
        bit         push;
        logic [7:0] wd;
        bit         pop;
        bit         clr;
        int         exp_txc;
        bit         exp_ep;
        bit         exp_eo;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: apply CPU inputs, advance the reference model, let the
    // edge happen, then run the uart model and compare everything.
    task automatic cycle(input bit push, input logic [7:0] wd, input bit pop, input bit clr);
        int tsz, rsz;
        bit exp_drain, exp_fill;
        logic [7:0] fill_byte, b, exp_head;
        tsz       = tx_q.size();
        rsz       = rx_q.size();
        exp_drain = (tsz != 0) && uart_tx_ready && !ref_wr;
        exp_fill  = uart_rx_full && !ref_rd && (rsz < DEPTH);
        fill_byte = uart_rx_data;
        tx_push = push; tx_wdata = wd; rx_pop = pop; err_clr = clr;
        if (push && tsz < DEPTH) tx_q.push_back(wd);
        if (pop && rsz > 0) void'(rx_q.pop_front());
        e_push = (push && tsz >= DEPTH) ? 1'b1 : (clr ? 1'b0 : e_push);
        e_pop  = (pop && rsz == 0)      ? 1'b1 : (clr ? 1'b0 : e_pop);
        @(negedge clk);
        tx_push = 1'b0; rx_pop = 1'b0; err_clr = 1'b0;
        chk("uart_wr", 32'(uart_wr), 32'(exp_drain));
        if (uart_wr) tx_log.push_back(uart_tx_data);
        if (exp_drain) begin
            b = tx_q.pop_front();
            chk("uart_tx_data", 32'(uart_tx_data), 32'(b));
        end
        ref_wr = exp_drain;
        if (uart_wr) busy = tx_gap;
        else if (busy > 0) busy--;
        uart_tx_ready = !tx_hold && (busy == 0);
        chk("uart_rd", 32'(uart_rd), 32'(exp_fill));
        if (exp_fill) rx_q.push_back(fill_byte);
        ref_rd = exp_fill;
        if (uart_rd) uart_rx_full = 1'b0;
        if (!uart_rx_full && rx_on && rx_src.size() > 0) begin
            uart_rx_data = rx_src.pop_front();
            uart_rx_full = 1'b1;
        end
        exp_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        chk("tx_count", 32'(tx_count), tx_q.size());
        chk("tx_full", 32'(tx_full), 32'(tx_q.size() == DEPTH));
        chk("rx_count", 32'(rx_count), rx_q.size());
        chk("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
        chk("rx_rdata", 32'(rx_rdata), 32'(exp_head));
        chk("err_push_full", 32'(err_push_full), 32'(e_push));
        chk("err_pop_empty", 32'(err_pop_empty), 32'(e_pop));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; tx_push = 1'b0; rx_pop = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        chk("rst_tx_count", 32'(tx_count), 0);
        chk("rst_rx_count", 32'(rx_count), 0);
        chk("rst_tx_full", 32'(tx_full), 0);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_rx_rdata", 32'(rx_rdata), 0);
        chk("rst_uart_wr", 32'(uart_wr), 0);
        chk("rst_uart_rd", 32'(uart_rd), 0);
        chk("rst_uart_tx_data", 32'(uart_tx_data), 0);
        chk("rst_err_push_full", 32'(err_push_full), 0);
        chk("rst_err_pop_empty", 32'(err_pop_empty), 0);
        rst = 1'b0;
        tx_q.delete(); rx_q.delete();
        ref_wr = 1'b0; ref_rd = 1'b0; e_push = 1'b0; e_pop = 1'b0;
        busy = 0;
        uart_tx_ready = !tx_hold;
    endtask

    initial begin
        rst = 1'b1; tx_push = 1'b0; tx_wdata = 8'h00; rx_pop = 1'b0; err_clr = 1'b0;
        uart_tx_ready = 1'b1; uart_rx_full = 1'b0; uart_rx_data = 8'h00;
        tx_hold = 1'b0; rx_on = 1'b0; tx_gap = 0; busy = 0;

        // Reset, then idle.
        do_reset();
        idle(3);

        // Error-flag vector table, uart not ready and no RX traffic.
        vecs[0] = '{push: 1'b0, wd: 8'h00, pop: 1'b1, clr: 1'b0, exp_txc: 0, exp_ep: 1'b0, exp_eo: 1'b1};
        vecs[1] = '{push: 1'b0, wd: 8'h00, pop: 1'b0, clr: 1'b1, exp_txc: 0, exp_ep: 1'b0, exp_eo: 1'b0};
        vecs[2] = '{push: 1'b0, wd: 8'h00, pop: 1'b1, clr: 1'b1, exp_txc: 0, exp_ep: 1'b0, exp_eo: 1'b1};
        vecs[3] = '{push: 1'b1, wd: 8'hA5, pop: 1'b0, clr: 1'b0, exp_txc: 1, exp_ep: 1'b0, exp_eo: 1'b1};
        vecs[4] = '{push: 1'b1, wd: 8'h5A, pop: 1'b0, clr: 1'b1, exp_txc: 2, exp_ep: 1'b0, exp_eo: 1'b0};
        vecs[5] = '{push: 1'b0, wd: 8'h00, pop: 1'b0, clr: 1'b0, exp_txc: 2, exp_ep: 1'b0, exp_eo: 1'b0};
        tx_hold = 1'b1; uart_tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].push, vecs[i].wd, vecs[i].pop, vecs[i].clr);
            chk("vec_tx_count", 32'(tx_count), vecs[i].exp_txc);
            chk("vec_err_push_full", 32'(err_push_full), 32'(vecs[i].exp_ep));
            chk("vec_err_pop_empty", 32'(err_pop_empty), 32'(vecs[i].exp_eo));
            chk("vec_rx_count", 32'(rx_count), 0);
        end

        // Three back-to-back pushes, uart busy for 10 cycles after each write.
        tx_hold = 1'b0; tx_gap = 10;
        do_reset();
        tx_log.delete();
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0);
        idle(45);
        chk("seq3_pulses", tx_log.size(), 3);
        if (tx_log.size() == 3) begin
            chk("seq3_byte0", 32'(tx_log[0]), 32'h41);
            chk("seq3_byte1", 32'(tx_log[1]), 32'h42);
            chk("seq3_byte2", 32'(tx_log[2]), 32'h43);
        end
        chk("seq3_tx_count", 32'(tx_count), 0);

        // 17 pushes into a FIFO that cannot drain.
        tx_hold = 1'b1; uart_tx_ready = 1'b0;
        tx_log.delete();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("ovf_tx_full", 32'(tx_full), 1);
        chk("ovf_tx_count", 32'(tx_count), 16);
        chk("ovf_err_push_full", 32'(err_push_full), 1);
        tx_hold = 1'b0; tx_gap = 0;
        idle(45);
        chk("ovf_pulses", tx_log.size(), 16);
        if (tx_log.size() == 16) chk("ovf_last_byte", 32'(tx_log[15]), 32'h6F);
        do_reset();

        // RX fill to capacity, backpressure, then drain.
        for (int i = 0; i <= 16; i++) rx_src.push_back(8'(i));
        rx_on = 1'b1;
        idle(45);
        chk("rxbp_rx_count", 32'(rx_count), 16);
        chk("rxbp_head", 32'(rx_rdata), 32'h00);
        chk("rxbp_uart_holds", 32'(uart_rx_full), 1);
        chk("rxbp_uart_byte", 32'(uart_rx_data), 32'h10);
        chk("rxbp_uart_rd", 32'(uart_rd), 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        chk("rxbp_taken", 32'(uart_rx_full), 0);
        chk("rxbp_count_after", 32'(rx_count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("rxbp_pop_data", 32'(rx_rdata), 32'(i + 1));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rxbp_empty", 32'(rx_empty), 1);
        rx_on = 1'b0;

        // Empty pop and set-wins-over-clear.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("epop_flag", 32'(err_pop_empty), 1);
        chk("epop_count", 32'(rx_count), 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("epop_set_wins", 32'(err_pop_empty), 1);

        // Reset while draining.
        do_reset();
        tx_hold = 1'b1; uart_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        tx_hold = 1'b0; tx_gap = 20; uart_tx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (uart_wr) break;
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end
        chk("mid_drain_wr_seen", 32'(uart_wr), 1);
        do_reset();
        tx_log.delete();
        idle(30);
        chk("mid_drain_no_pulses", tx_log.size(), 0);

        // Randomized traffic on both FIFOs.
        do_reset();
        rx_on = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) tx_gap = int'($urandom_range(0, 3));
            if (rx_src.size() < 4 && $urandom_range(0, 2) == 0) rx_src.push_back(8'($urandom));
            cycle(($urandom_range(0, 9) < 6), 8'($urandom),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
        end
        rx_on = 1'b0;
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_buf.md
# uart_buf

Byte-buffering stage between the CPU I/O bus and the `uart` core. It holds outgoing bytes in a TX FIFO and drains them into the uart's `tx_data`/`wr`/`tx_ready` handshake one byte at a time. It also pulls each received byte out of the uart's single-entry `rx_data`/`rx_full`/`rd` buffer into an RX FIFO. This lets software burst writes and tolerate read latency without losing bytes.

## Interface
Parameters:
- `DATA_BITS`, default 8: byte width; must match the uart instance.
- `DEPTH_LOG2`, default 4: each FIFO holds `DEPTH = 2**DEPTH_LOG2` entries.

Ports:
- `clk`  in  1  clock; single clock domain, shared with `uart`.
- `rst`  in  1  reset; synchronous, active-high.
- `tx_wdata`  in  DATA_BITS  byte to enqueue.
- `tx_push`  in  1  enqueue `tx_wdata` this cycle.
- `tx_full`  out  1  TX FIFO holds DEPTH entries.
- `tx_count`  out  DEPTH_LOG2+1  TX occupancy.
- `rx_rdata`  out  DATA_BITS  RX FIFO head (show-ahead); 0 when empty.
- `rx_pop`  in  1  dequeue the head this cycle.
- `rx_empty`  out  1  RX FIFO holds 0 entries.
- `rx_count`  out  DEPTH_LOG2+1  RX occupancy.
- `err_push_full`  out  1  sticky; set when a push is dropped.
- `err_pop_empty`  out  1  sticky; set when a pop is ignored.
- `err_clr`  in  1  clears both sticky flags.
- `uart_tx_data`  out  DATA_BITS  to uart `tx_data`.
- `uart_wr`  out  1  to uart `wr`; registered one-cycle pulse.
- `uart_tx_ready`  in  1  from uart `tx_ready`.
- `uart_rx_data`  in  DATA_BITS  from uart `rx_data`.
- `uart_rx_full`  in  1  from uart `rx_full`.
- `uart_rd`  out  1  to uart `rd`; registered one-cycle pulse.

## Operation
- Each FIFO is a circular buffer of DEPTH entries:
  - write and read pointers are DEPTH_LOG2 bits wide and wrap naturally at DEPTH-1 → 0;
  - occupancy is a separate DEPTH_LOG2+1-bit counter.
- CPU TX push:
  - if `tx_push` and `tx_count < DEPTH`: write `tx_wdata` and increment the write pointer;
  - if `tx_push` and the FIFO is full: drop the byte and set `err_push_full`.
- TX drain:
  - condition: `tx_count != 0 && uart_tx_ready && !uart_wr`;
  - action: register `uart_tx_data <= head`, `uart_wr <= 1`, advance the read pointer;
  - otherwise `uart_wr <= 0`.
- The `!uart_wr` guard prevents a second issue while the uart's `tx_ready` is still settling.
- RX fill:
  - condition: `uart_rx_full && !uart_rd && rx_count < DEPTH`;
  - action: write `uart_rx_data` into the RX FIFO, `uart_rd <= 1`;
  - otherwise `uart_rd <= 0`.
- RX backpressure: when the RX FIFO is full, the byte stays in the uart and `uart_rd` is not asserted.
- The full test uses occupancy before this cycle's pop. A full FIFO with a simultaneous `rx_pop` does not accept the uart byte this cycle; it is taken on the next cycle.
- CPU RX pop:
  - if `rx_pop` and not empty: advance the read pointer;
  - if `rx_pop` and empty: ignore the pop and set `err_pop_empty`.
- Simultaneous push and pop on one FIFO: both take effect and the count is unchanged. TX push and drain may coincide; RX fill and pop may coincide.
- Error flags:
  - `err_clr` clears both flags;
  - a set event in the same cycle as `err_clr` wins (the flag reads 1).
- Reset values:
  - pointers and counts 0;
  - `tx_full=0`, `rx_empty=1`, `rx_rdata=0`;
  - `uart_wr=0`, `uart_rd=0`, `uart_tx_data=0`;
  - both error flags 0.
- Reset mid-operation discards all FIFO contents. It does not touch the uart, which has its own reset.

## Timing
- TX latency: a `tx_push` at edge N into an empty FIFO, with `uart_tx_ready=1` in cycle N+1, gives `uart_wr=1` and valid `uart_tx_data` during cycle N+2.
- `uart_tx_data` holds its value until the next issue.
- `uart_wr` is never high for two consecutive cycles.
- RX latency: `uart_rx_full` rising, visible in cycle M, gives:
  - the byte written and `uart_rd=1` during cycle M+1;
  - `rx_empty=0` and `rx_rdata` valid in cycle M+1.
- The uart clears `rx_full` at the end of M+1.
- If the uart completes a new byte on that same edge, `rx_full` stays 1 and the new byte is taken in M+2 (`!uart_rd` re-arms).
- Byte completions closer than 2 cycles apart do not occur at any legal baud; no handling is required.
- `rx_rdata` and all status outputs reflect registered state. There is no combinational path from `rx_pop`/`tx_push` to them.

## Test plan
- Reset, then idle → `rx_empty=1`, `tx_full=0`, both counts 0, `uart_wr=0`, `uart_rd=0`.
- Push 0x41, 0x42, 0x43 back-to-back, with a uart model that drops ready for 10 cycles after each `wr` → exactly three single-cycle `uart_wr` pulses carrying 0x41, 0x42, 0x43 in order; `tx_count` returns to 0.
- 17 pushes with `uart_tx_ready=0` (DEPTH=16) → `tx_full=1`, `tx_count=16`, `err_push_full=1`; the 17th byte never appears on `uart_tx_data`.
- Uart model delivers 0x00..0x0F, then 0x10, with no pops:
  - the FIFO fills;
  - 0x10 remains in the uart with `uart_rd` low;
  - one `rx_pop` → 0x10 is accepted within 2 cycles;
  - 16 subsequent pops read 0x01..0x10.
- `rx_pop` on an empty FIFO → `err_pop_empty=1`, count stays 0; `err_clr` asserted together with a new empty pop → flag stays 1.
- Assert `rst` mid-drain, with 5 bytes queued and `uart_wr` high → next cycle all counts 0, `uart_wr=0`, and no further `uart_wr` pulses.
